// File: rtl/flow_arb_ctrl.sv
// flow_arb_ctrl: round-robin two-requester arbiter with registered tag-sanitize stage before a valid/ready output.
// Define FLOW_ARB_BLK_CNT_EN to add the saturating blocked-transfer counter blk_cnt.
module flow_arb_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_data,
  input  logic [3:0]   req0_tag,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_data,
  input  logic [3:0]   req1_tag,
  output logic         req1_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_src,
  output logic         out_blocked,
  input  logic         out_ready
`ifdef FLOW_ARB_BLK_CNT_EN
  ,
  output logic [7:0]   blk_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, CHECK, SEND} state_t;
  state_t state, state_nx;
  logic last, win, hs, stage_src, stage_blk;
  logic [W-1:0] stage_data;
  logic [3:0] stage_tag;
  always_comb begin
    win = (req0_valid && req1_valid) ? ~last : req1_valid;
    req0_ready = state == IDLE && req0_valid && !win;
    req1_ready = state == IDLE && req1_valid && win;
    hs = req0_ready || req1_ready;
    state_nx = state == IDLE ? (hs ? CHECK : IDLE) : state == CHECK ? SEND : (out_ready ? IDLE : SEND);
    out_valid = state == SEND;
    out_data = (out_valid && !stage_blk) ? stage_data : '0;
    out_src = out_valid && stage_src;
    out_blocked = out_valid && stage_blk;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last <= 1'b1;
      stage_data <= '0;
      stage_tag <= '0;
      stage_src <= 1'b0;
      stage_blk <= 1'b0;
    end else begin
      if (hs) begin
        stage_data <= win ? req1_data : req0_data;
        stage_tag <= win ? req1_tag : req0_tag;
        stage_src <= win;
        last <= win;
      end
      if (state == CHECK) stage_blk <= stage_tag == 4'h0 || stage_tag == 4'hA;
    end
`ifdef FLOW_ARB_BLK_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) blk_cnt <= '0;
    else if (state == SEND && out_ready && stage_blk && blk_cnt != 8'hFF) blk_cnt <= blk_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_flow_arb_ctrl.sv
// tb_flow_arb_ctrl: directed and random stimulus against a transaction-level model of the arbiter.
module tb_flow_arb_ctrl;
  localparam int W = 8;
  logic clk = 0, rst_n = 0;
  logic req0_valid = 0, req1_valid = 0, out_ready = 0;
  logic [W-1:0] req0_data = 0, req1_data = 0;
  logic [3:0] req0_tag = 0, req1_tag = 0;
  logic req0_ready, req1_ready, out_valid, out_src, out_blocked;
  logic [W-1:0] out_data;
  int checks = 0, errors = 0;
  bit m_last, m_busy, m_src, m_blk;
  int m_age, m_cnt;
  logic [W-1:0] m_data;
  int grants[$];
  logic [W-1:0] outs[$];
`ifdef FLOW_ARB_BLK_CNT_EN
  logic [7:0] blk_cnt;
`endif

  flow_arb_ctrl #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_tag(req0_tag), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_tag(req1_tag), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_blocked(out_blocked),
    .out_ready(out_ready)
`ifdef FLOW_ARB_BLK_CNT_EN
    , .blk_cnt(blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1; m_busy = 0; m_src = 0; m_blk = 0; m_age = 0; m_cnt = 0; m_data = 0;
  endtask

  // One clock: drive inputs after the falling edge, check, then advance the model over the rising edge.
  task automatic cyc(input logic v0, input logic [W-1:0] d0, input logic [3:0] t0,
                     input logic v1, input logic [W-1:0] d1, input logic [3:0] t1, input logic rdy);
    bit w, ov;
    @(negedge clk);
    req0_valid = v0; req0_data = d0; req0_tag = t0;
    req1_valid = v1; req1_data = d1; req1_tag = t1; out_ready = rdy;
    #1;
    w = (v0 && v1) ? !m_last : v1;
    ov = m_busy && m_age >= 1;
    chk("req0_ready", req0_ready, !m_busy && v0 && !w);
    chk("req1_ready", req1_ready, !m_busy && v1 && w);
    chk("out_valid", out_valid, ov);
    chk("out_data", out_data, (ov && !m_blk) ? m_data : '0);
    chk("out_src", out_src, ov && m_src);
    chk("out_blocked", out_blocked, ov && m_blk);
`ifdef FLOW_ARB_BLK_CNT_EN
    chk("blk_cnt", blk_cnt, m_cnt);
`endif
    if (out_valid && rdy) outs.push_back(out_data);
    if (!m_busy) begin
      if (v0 || v1) begin
        m_busy = 1; m_age = 0; m_src = w; m_last = w;
        m_data = w ? d1 : d0;
        m_blk = (w ? t1 : t0) inside {4'h0, 4'hA};
        grants.push_back(w);
      end
    end else if (ov && rdy) begin
      m_busy = 0;
      if (m_blk && m_cnt < 255) m_cnt++;
    end else m_age++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_out_blocked", out_blocked, 0);
`ifdef FLOW_ARB_BLK_CNT_EN
    chk("rst_blk_cnt", blk_cnt, 0);
`endif
    model_reset();
    req0_valid = 0; req1_valid = 0; out_ready = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    do_reset();
    // basic forward
    outs.delete();
    cyc(1, 8'h5C, 4'h3, 0, 0, 0, 1);
    chk("basic_ready0", req0_ready, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("basic_valid", out_valid, 1);
    chk("basic_data", outs.size() == 1 ? outs[0] : 8'hxx, 8'h5C);
    // sanitize
    outs.delete();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 8'hFF, 4'hA, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 8'hFF, 4'h0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 8'hFF, 4'hB, 1);
    chk("san_count", outs.size(), 3);
    if (outs.size() == 3) begin
      chk("san_tagA", outs[0], 8'h00);
      chk("san_tag0", outs[1], 8'h00);
      chk("san_tagB", outs[2], 8'hFF);
    end
    // round-robin after a fresh reset
    do_reset();
    grants.delete();
    for (int i = 0; i < 12; i++) cyc(1, 8'h11, 4'h1, 1, 8'h22, 4'h2, 1);
    chk("rr_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("rr_src", grants[i], i % 2);
    // backpressure: SEND held 5 cycles with both requesters valid
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 8'h33, 4'h5, 0, 0, 0, 0);
    cyc(1, 8'h44, 4'h5, 1, 8'h55, 4'h5, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'h44, 4'h5, 1, 8'h55, 4'h5, 0);
      chk("bp_data", out_data, 8'h33);
    end
    cyc(1, 8'h44, 4'h5, 1, 8'h55, 4'h5, 1);
    cyc(0, 8'h44, 4'h5, 1, 8'h55, 4'h5, 1);
    chk("bp_ready1", req1_ready, 1);
    // reset while the word is in CHECK
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 8'h66, 4'h7, 1);
    do_reset();
    grants.delete();
    for (int i = 0; i < 3; i++) cyc(1, 8'h77, 4'h7, 1, 8'h88, 4'h8, 1);
    chk("rst_first_grant", grants.size() > 0 ? grants[0] : 99, 0);
`ifdef FLOW_ARB_BLK_CNT_EN
    for (int i = 0; i < 300; i++) for (int j = 0; j < 3; j++) cyc(1, 8'h99, 4'h0, 0, 0, 0, 1);
    chk("cnt_sat", blk_cnt, 8'hFF);
    for (int j = 0; j < 3; j++) cyc(1, 8'h99, 4'h9, 0, 0, 0, 1);
    chk("cnt_hold", blk_cnt, 8'hFF);
`endif
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 1), W'($urandom), 4'($urandom_range(0, 15)),
          $urandom_range(0, 1), W'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
